neuron_mac: RTL and testbench

Sequential multiply-accumulate engine for one neuron of the ANN datapath: accepts a bias, then a stream of N_INPUTS signed feature/weight pairs over a valid/ready handshake, and produces the signed pre-activation sum. It sits upstream of the ReLU activation stage and drives that stage's data input, its `mac_en` busy indication, and its `en` completion strobe.

---
 rtl/ann_pkg.sv | 10 +
 rtl/neuron_mac_if.sv | 26 ++
 rtl/mac_mul_stage.sv | 26 ++
 rtl/neuron_mac.sv | 65 ++++++
 tb/tb_neuron_mac.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/ann_pkg.sv
// ann_pkg: shared FSM encoding and width helpers for the neuron datapath
package ann_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_e;
  function automatic int prod_w(input int feature_wide, input int weight_wide);
    return feature_wide + weight_wide;
  endfunction
  function automatic int acc_w(input int feature_wide);
    return feature_wide + 16;
  endfunction
endpackage

// File: rtl/neuron_mac_if.sv
// neuron_mac_if: start/bias, feature-weight stream and result bundle of one neuron
interface neuron_mac_if
  import ann_pkg::*;
#(
  parameter int FEATURE_WIDE = 4,
  parameter int WEIGHT_WIDE = 12
);
  localparam int ACC_W = acc_w(FEATURE_WIDE);
  logic start;
  logic signed [ACC_W-1:0] bias;
  logic in_valid;
  logic in_ready;
  logic signed [FEATURE_WIDE-1:0] in_feature;
  logic signed [WEIGHT_WIDE-1:0] in_weight;
  logic signed [ACC_W-1:0] acc_data;
  logic mac_en;
  logic en;
  modport master(
    output start, bias, in_valid, in_feature, in_weight,
    input in_ready, acc_data, mac_en, en
  );
  modport slave(
    input start, bias, in_valid, in_feature, in_weight,
    output in_ready, acc_data, mac_en, en
  );
endinterface

// File: rtl/mac_mul_stage.sv
// mac_mul_stage: registered signed multiplier with a valid flag
module mac_mul_stage
  import ann_pkg::*;
#(
  parameter int A_W = 4,
  parameter int B_W = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic signed [A_W-1:0] a_i,
  input  logic signed [B_W-1:0] b_i,
  input  logic vld_i,
  output logic signed [prod_w(A_W, B_W)-1:0] p_o,
  output logic p_vld_o
);
  localparam int P_W = prod_w(A_W, B_W);
  logic signed [P_W-1:0] p_q, p_d;
  logic p_vld_q;
  assign p_d = vld_i ? a_i * b_i : p_q;
  always_ff @(posedge clk) begin
    p_q <= p_d;
    p_vld_q <= rst ? 1'b0 : vld_i;
  end
  assign p_o = p_q;
  assign p_vld_o = p_vld_q;
endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: bias-seeded multiply-accumulate over N_INPUTS handshaked pairs
module neuron_mac
  import ann_pkg::*;
#(
  parameter int FEATURE_WIDE = 4,
  parameter int WEIGHT_WIDE = 12,
  parameter int N_INPUTS = 16
) (
  input logic clk,
  input logic rst,
  neuron_mac_if.slave bus
);
  localparam int PROD_W = prod_w(FEATURE_WIDE, WEIGHT_WIDE);
  localparam int ACC_W = acc_w(FEATURE_WIDE);
  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [PROD_W-1:0] p_q;
  logic p_vld, go, accept;
  assign go = state_q == IDLE && bus.start;
  assign accept = state_q == ACC && bus.in_valid;
  mac_mul_stage #(.A_W(FEATURE_WIDE), .B_W(WEIGHT_WIDE)) u_mul (
    .clk(clk),
    .rst(rst),
    .a_i(bus.in_feature),
    .b_i(bus.in_weight),
    .vld_i(accept),
    .p_o(p_q),
    .p_vld_o(p_vld)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = go ? ACC : IDLE;
      ACC: state_d = accept && cnt_q == LAST ? DRAIN : ACC;
      DRAIN: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // the last product lands during DRAIN, so the sum is final on entry to DONE
  always_comb begin
    cnt_d = go ? '0 : accept ? cnt_q + CNT_W'(1) : cnt_q;
    acc_d = go ? bus.bias : p_vld ? acc_q + ACC_W'(p_q) : acc_q;
  end
  always_comb begin
    bus.in_ready = state_q == ACC;
    bus.mac_en = state_q == ACC || state_q == DRAIN;
    bus.en = state_q == DONE;
    bus.acc_data = acc_q;
  end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed vector table plus hand-written corner sequences
module tb_neuron_mac;
  import ann_pkg::*;
  localparam int FW = 4;
  localparam int WW = 12;
  localparam int AW = 20;
  typedef struct {
    logic signed [AW-1:0] bias;
    logic [3:0][FW-1:0] f;
    logic [3:0][WW-1:0] w;
    int gap;
    logic signed [AW-1:0] exp_acc;
    int exp_en;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  neuron_mac_if #(.FEATURE_WIDE(FW), .WEIGHT_WIDE(WW)) ba ();
  neuron_mac_if #(.FEATURE_WIDE(FW), .WEIGHT_WIDE(WW)) bb ();
  neuron_mac #(.FEATURE_WIDE(FW), .WEIGHT_WIDE(WW), .N_INPUTS(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ba)
  );
  neuron_mac #(.FEATURE_WIDE(FW), .WEIGHT_WIDE(WW), .N_INPUTS(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bb)
  );
  int errors = 0;
  int checks = 0;
  logic en_h[32], mac_h[32], rdy_h[32];
  logic signed [AW-1:0] acc_h[32];
  vec_t vecs[4];
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input int b, input int f0, f1, f2, f3,
                              input int w0, w1, w2, w3, input int gap, acc, en_c);
    vec_t v;
    v.bias = AW'(b);
    v.f[0] = FW'(f0); v.f[1] = FW'(f1); v.f[2] = FW'(f2); v.f[3] = FW'(f3);
    v.w[0] = WW'(w0); v.w[1] = WW'(w1); v.w[2] = WW'(w2); v.w[3] = WW'(w3);
    v.gap = gap;
    v.exp_acc = AW'(acc);
    v.exp_en = en_c;
    return v;
  endfunction
  // cycle 0 carries start; each cycle samples outputs first, then drives inputs
  task automatic run_a(input vec_t v, input logic [31:0] start_mask, input int rst_cyc, input int ncyc);
    int k;
    int gl;
    logic vld;
    k = 0;
    gl = v.gap;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      en_h[c] = ba.en;
      mac_h[c] = ba.mac_en;
      rdy_h[c] = ba.in_ready;
      acc_h[c] = ba.acc_data;
      ba.start = (c == 0) || start_mask[c];
      ba.bias = v.bias;
      rst = (c == rst_cyc);
      vld = k < 4;
      if (k == 2 && gl > 0) begin
        vld = 1'b0;
        gl--;
      end
      ba.in_valid = vld;
      ba.in_feature = v.f[k < 4 ? k : 0];
      ba.in_weight = v.w[k < 4 ? k : 0];
      if (vld && ba.in_ready) k++;
    end
    ba.start = 1'b0;
    ba.in_valid = 1'b0;
    rst = 1'b0;
  endtask
  function automatic int en_first(input int ncyc);
    for (int c = 0; c < ncyc; c++) if (en_h[c]) return c;
    return -1;
  endfunction
  function automatic int en_count(input int ncyc);
    int n = 0;
    for (int c = 0; c < ncyc; c++) if (en_h[c]) n++;
    return n;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int bad;
    int kb;
    ba.start = 0; ba.bias = '0; ba.in_valid = 0; ba.in_feature = '0; ba.in_weight = '0;
    bb.start = 0; bb.bias = '0; bb.in_valid = 0; bb.in_feature = '0; bb.in_weight = '0;
    vecs[0] = mk(10, 1, 2, 3, 4, 5, 6, 7, 8, 0, 80, 6);
    vecs[1] = mk(10, 1, 2, 3, 4, 5, 6, 7, 8, 3, 80, 9);
    vecs[2] = mk(0, -8, 7, -8, 7, 2047, -2048, 2047, -2048, 0, -61424, 6);
    vecs[3] = mk(-100, -1, -1, -1, -1, 1, 2, 3, 4, 1, -110, 7);
    repeat (3) @(negedge clk);
    chk("reset_acc", ba.acc_data, 0);
    chk("reset_mac_en", ba.mac_en, 0);
    chk("reset_en", ba.en, 0);
    chk("reset_in_ready", ba.in_ready, 0);
    chk("reset_b_acc", bb.acc_data, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      run_a(vecs[i], 32'h0, -1, 16);
      chk($sformatf("v%0d_en_cycle", i), en_first(16), vecs[i].exp_en);
      chk($sformatf("v%0d_en_count", i), en_count(16), 1);
      chk($sformatf("v%0d_acc_final", i), acc_h[vecs[i].exp_en], vecs[i].exp_acc);
      chk($sformatf("v%0d_acc_hold", i), acc_h[vecs[i].exp_en + 2], vecs[i].exp_acc);
      chk($sformatf("v%0d_ready_c0", i), rdy_h[0], 0);
      chk($sformatf("v%0d_ready_c1", i), rdy_h[1], 1);
      bad = 0;
      for (int c = 0; c < 16; c++)
        if (mac_h[c] !== (c >= 1 && c < vecs[i].exp_en)) bad++;
      chk($sformatf("v%0d_mac_en_pattern", i), bad, 0);
    end
    // start during ACC (c2) and during en (c6) are ignored; start at c7 is taken
    run_a(vecs[0], 32'h0000_00C4, -1, 10);
    chk("ign_en_cycle", en_first(10), 6);
    chk("ign_en_count", en_count(10), 1);
    chk("ign_acc", acc_h[6], 80);
    chk("ign_mac_en_c7", mac_h[7], 0);
    chk("ign_mac_en_c8", mac_h[8], 1);
    chk("ign_ready_c8", rdy_h[8], 1);
    chk("ign_bias_load", acc_h[8], 10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_mac_en", ba.mac_en, 0);
    // reset lands while the engine is in DRAIN (cycle 5)
    run_a(vecs[0], 32'h0, 5, 16);
    chk("rst_drain_mac_en_c5", mac_h[5], 1);
    chk("rst_drain_acc", acc_h[6], 0);
    chk("rst_drain_mac_en", mac_h[6], 0);
    chk("rst_drain_ready", rdy_h[6], 0);
    chk("rst_drain_no_en", en_count(16), 0);
    kb = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      en_h[c] = bb.en;
      mac_h[c] = bb.mac_en;
      acc_h[c] = bb.acc_data;
      bb.start = (c == 0);
      bb.bias = -20'sd3;
      bb.in_valid = (kb == 0);
      bb.in_feature = 4'sd2;
      bb.in_weight = -12'sd1;
      if (bb.in_valid && bb.in_ready) kb = 1;
    end
    bb.start = 1'b0;
    bb.in_valid = 1'b0;
    chk("n1_en_cycle", en_first(8), 3);
    chk("n1_en_count", en_count(8), 1);
    chk("n1_acc", acc_h[3], -5);
    chk("n1_mac_en_c1", mac_h[1], 1);
    chk("n1_mac_en_c2", mac_h[2], 1);
    chk("n1_mac_en_c3", mac_h[3], 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
